alu_md: RTL and testbench
=========================

# alu_md

Parametrised, handshaked successor to the core's combinational integer ALU. Executes the existing single-cycle operations (mov, add, sub, logic, shifts, compares, low multiply) with a registered result, and adds iterative multi-cycle operations: high-half multiply and signed/unsigned divide/remainder. Sits in the EX stage behind a valid/ready handshake, so the pipeline stalls while a long operation runs.

## Interface
Parameters:
- WIDTH, 32: operand/result width; ≥ 8, power of two.
- SHW, $clog2(WIDTH): shift-amount width (derived; not overridden).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block accepts a request this cycle.
- op  in  6  operation code (see Operation).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  consumer takes result this cycle.
- result  out  WIDTH  registered result.
- busy  out  1  high in state RUN.

## Operation
- Op codes. Single-cycle class:
  - 0x00 mov (A); 0x01 add; 0x02 sub (A−B); 0x03 and; 0x04 or; 0x05 xor.
  - 0x06 sll (B << A[SHW-1:0]); 0x07 sra (B arithmetic >> A[SHW-1:0]); 0x08 srl (B logical >> A[SHW-1:0]).
  - 0x09 slt (signed A<B → 1 else 0); 0x0A sltu (unsigned); 0x0B mul (low WIDTH bits of A*B).
- Op codes. Iterative class:
  - 0x0C mulh (signed×signed, high half); 0x0D mulhu (unsigned, high half); 0x0E mulhsu (A signed, B unsigned, high half).
  - 0x0F div; 0x10 divu; 0x11 rem; 0x12 remu.
- Undefined op: treated as single-cycle, result 0.
- All arithmetic wraps modulo 2^WIDTH. Shift amount uses only the low SHW bits of A.
- Divide by zero: div/divu → all ones; rem/remu → A.
- Signed overflow (A = 1<<(WIDTH-1), B = −1): div → A; rem → 0.
- Iterative ops use operand magnitudes and apply sign fix-up in the final cycle. Quotient truncates toward zero; remainder takes the sign of A.
- FSM states:
  - IDLE: in_ready=1. Accepting a single-cycle op → DONE with result loaded. Accepting an iterative op → RUN, counter = WIDTH−1, operands latched.
  - RUN: one shift-add (mul) or one restoring subtract (div) step per cycle; counter decrements. At counter 0 → FIX.
  - FIX: sign correction and zero/overflow override; result loaded → DONE.
  - DONE: out_valid=1. If out_ready and in_valid, the next request is accepted in the same cycle (in_ready=out_ready) and its transition is taken as from IDLE. If out_ready only → IDLE.
- Inputs are sampled only on an accepted handshake; changes during RUN are ignored.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, busy 0, in_ready 1 (combinational from state), counter 0.
- Single-cycle ops: accept at edge N, out_valid at N+1. Back-to-back throughput is 1 per cycle while out_ready=1.
- Iterative ops: accept at N, RUN for WIDTH cycles, FIX 1 cycle, out_valid at N+WIDTH+2. Divide-by-zero and overflow take full latency (no early exit).
- out_valid with out_ready low: result and out_valid stable; in_ready 0.
- rst asserted mid-RUN or mid-DONE: immediately returns to reset values; the pending result is lost; no output glitch after release.

## Structure
- Package alu_md_pkg holds:
  - op code localparams/enum (6-bit);
  - FSM state enum (IDLE, RUN, FIX, DONE);
  - is_iterative(op) function.
- Sub-module alu_md_iter: shared WIDTH-step shift-add multiplier / restoring divider datapath, with a 2·WIDTH accumulator, counter, and sign flags. The top module holds the single-cycle ALU, FSM, and handshake.

## Test plan
- Reset, then add 0x7FFFFFFF+1 with out_ready=1 → out_valid 1 cycle after accept, result 0x80000000; sltu 1,0xFFFFFFFF → 1; slt same → 0.
- sra A=4, B=0xF0000000 → 0xFF000000; srl → 0x0F000000; sll A=36, B=1 → 0x10 (shift masked to 4).
- mulh 0xFFFFFFFF×0xFFFFFFFF → 0; mulhu same → 0xFFFFFFFE; mulhsu −1×2 → 0xFFFFFFFF. out_valid exactly 34 cycles after accept.
- div −7/2 → 0xFFFFFFFD, rem → 0xFFFFFFFF; divu 7/0 → 0xFFFFFFFF, remu → 7; div 0x80000000/−1 → 0x80000000, rem → 0.
- Backpressure: hold out_ready=0 for 5 cycles after a result → result stable, in_ready 0. Then out_ready=1 with new in_valid → accepted same cycle, next result 1 cycle later.
- Assert rst at RUN cycle 10 of a divu → out_valid 0, busy 0 immediately. A new add after release completes normally.

Source files
------------

// File: rtl/alu_md_pkg.sv
// Shared definitions for alu_md: operation codes, controller states and op classification.
package alu_md_pkg;

    localparam logic [5:0] OP_MOV    = 6'h00;
    localparam logic [5:0] OP_ADD    = 6'h01;
    localparam logic [5:0] OP_SUB    = 6'h02;
    localparam logic [5:0] OP_AND    = 6'h03;
    localparam logic [5:0] OP_OR     = 6'h04;
    localparam logic [5:0] OP_XOR    = 6'h05;
    localparam logic [5:0] OP_SLL    = 6'h06;
    localparam logic [5:0] OP_SRA    = 6'h07;
    localparam logic [5:0] OP_SRL    = 6'h08;
    localparam logic [5:0] OP_SLT    = 6'h09;
    localparam logic [5:0] OP_SLTU   = 6'h0A;
    localparam logic [5:0] OP_MUL    = 6'h0B;
    localparam logic [5:0] OP_MULH   = 6'h0C;
    localparam logic [5:0] OP_MULHU  = 6'h0D;
    localparam logic [5:0] OP_MULHSU = 6'h0E;
    localparam logic [5:0] OP_DIV    = 6'h0F;
    localparam logic [5:0] OP_DIVU   = 6'h10;
    localparam logic [5:0] OP_REM    = 6'h11;
    localparam logic [5:0] OP_REMU   = 6'h12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic is_iterative(input logic [5:0] op);
        return (op >= OP_MULH) && (op <= OP_REMU);
    endfunction

    function automatic logic is_divide(input logic [5:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Shared WIDTH-step datapath: shift-add multiplier on magnitudes, or restoring divider,
// with sign correction and divide-by-zero / overflow overrides applied to o_result.
module alu_md_iter
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_step,
    input  logic [5:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_result
);

    localparam int SHW = $clog2(WIDTH);

    logic                 w_signed_a;
    logic                 w_signed_b;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic                 w_is_div;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;

    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_a_orig;
    logic [SHW-1:0]       r_cnt;
    logic                 r_is_div;
    logic                 r_ret_rem;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_b_zero;
    logic                 r_ovf;

    logic [WIDTH-1:0]     w_hi;
    logic [WIDTH-1:0]     w_lo;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [WIDTH-1:0]     w_mul_hi;

    assign w_signed_a = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_signed_b = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_a_neg    = w_signed_a && i_a[WIDTH-1];
    assign w_b_neg    = w_signed_b && i_b[WIDTH-1];
    assign w_is_div   = is_divide(i_op);
    assign w_mag_a    = w_a_neg ? -i_a : i_a;
    assign w_mag_b    = w_b_neg ? -i_b : i_b;

    assign w_hi = r_acc[2*WIDTH-1:WIDTH];
    assign w_lo = r_acc[WIDTH-1:0];

    // Multiply: add multiplicand into the upper half when the next multiplier bit is set, then shift right.
    assign w_sum      = {1'b0, w_hi} + {1'b0, (r_acc[0] ? r_mcand : {WIDTH{1'b0}})};
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // Divide: shift one dividend bit into the remainder and keep the subtraction only if it did not borrow.
    assign w_rem_sh   = {w_hi, r_acc[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_mcand};
    assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    assign o_last = (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_a_orig  <= '0;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_ret_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_b_zero  <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (i_start) begin
            r_is_div  <= w_is_div;
            r_ret_rem <= (i_op == OP_REM) || (i_op == OP_REMU);
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_b_zero  <= (i_b == '0);
            r_ovf     <= w_signed_b && w_is_div &&
                         (i_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_b == {WIDTH{1'b1}});
            r_a_orig  <= i_a;
            r_cnt     <= SHW'(WIDTH-1);
            r_acc     <= w_is_div ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
            r_mcand   <= w_is_div ? w_mag_b : w_mag_a;
        end else if (i_step) begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= o_last ? r_cnt : r_cnt - SHW'(1);
        end
    end

    // High half of the negated product: ~hi plus the carry out of negating the low half.
    assign w_mul_hi = r_neg_q ? (~w_hi + {{(WIDTH-1){1'b0}}, (w_lo == '0)}) : w_hi;

    always_comb begin
        o_result = w_mul_hi;
        if (r_is_div) begin
            if (r_b_zero) begin
                o_result = r_ret_rem ? r_a_orig : {WIDTH{1'b1}};
            end else if (r_ovf) begin
                o_result = r_ret_rem ? {WIDTH{1'b0}} : r_a_orig;
            end else if (r_ret_rem) begin
                o_result = r_neg_r ? -w_hi : w_hi;
            end else begin
                o_result = r_neg_q ? -w_lo : w_lo;
            end
        end
    end

endmodule

// File: rtl/alu_md.sv
// EX-stage integer ALU with valid/ready handshake; single-cycle ops register in one cycle,
// multiply-high and divide/remainder iterate in alu_md_iter. States: IDLE accept | RUN iterate | FIX correct | DONE hold.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_e           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;

    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_accept;
    logic             w_iter_start;
    logic             w_iter_step;
    logic             w_iter_last;
    logic [WIDTH-1:0] w_iter_result;

    assign w_shamt = a[SHW-1:0];

    always_comb begin
        w_alu_res = '0;
        case (op)
            OP_MOV:  w_alu_res = a;
            OP_ADD:  w_alu_res = a + b;
            OP_SUB:  w_alu_res = a - b;
            OP_AND:  w_alu_res = a & b;
            OP_OR:   w_alu_res = a | b;
            OP_XOR:  w_alu_res = a ^ b;
            OP_SLL:  w_alu_res = b << w_shamt;
            OP_SRA:  w_alu_res = $signed(b) >>> w_shamt;
            OP_SRL:  w_alu_res = b >> w_shamt;
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MUL:  w_alu_res = a * b;
            default: w_alu_res = '0;
        endcase
    end

    // DONE frees the slot in the same cycle the consumer takes the result.
    assign in_ready     = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept     = in_valid && in_ready;
    assign w_iter_start = w_accept && is_iterative(op);
    assign w_iter_step  = (r_state == S_RUN);

    alu_md_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_iter_start),
        .i_step   (w_iter_step),
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .o_last   (w_iter_last),
        .o_result (w_iter_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        if (is_iterative(op)) begin
                            r_state     <= S_RUN;
                            r_busy      <= 1'b1;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state     <= S_DONE;
                            r_result    <= w_alu_res;
                            r_out_valid <= 1'b1;
                        end
                    end else if ((r_state == S_DONE) && out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_iter_last) begin
                        r_state <= S_FIX;
                        r_busy  <= 1'b0;
                    end
                end
                S_FIX: begin
                    r_state     <= S_DONE;
                    r_result    <= w_iter_result;
                    r_out_valid <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign busy      = r_busy;

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md: expected results and latencies are queued on each accepted request
// and compared by an independent monitor whenever the block presents a result.
module tb_alu_md;

    localparam int WIDTH    = 32;
    localparam int ITER_LAT = WIDTH + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  result;
    logic              busy;

    always #5 clk = ~clk;

    alu_md #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] res;
        int          acc_cyc;
        int          lat;
        logic [5:0]  op;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   rand_bp  = 1'b0;
    bit   prev_ov  = 1'b0;
    bit   prev_take = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_iter(input logic [5:0] o);
        return (o >= 6'h0C) && (o <= 6'h12);
    endfunction

    // Reference behaviour from the operation table, using 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx  = longint'($signed(x));
        longint      sy  = longint'($signed(y));
        longint      ux  = longint'({32'h0, x});
        longint      uy  = longint'({32'h0, y});
        int          ix  = $signed(x);
        int          iy  = $signed(y);
        logic [4:0]  sh  = x[4:0];
        bit          ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        logic [63:0] p;
        case (o)
            6'h00: return x;
            6'h01: return x + y;
            6'h02: return x - y;
            6'h03: return x & y;
            6'h04: return x | y;
            6'h05: return x ^ y;
            6'h06: return y << sh;
            6'h07: return 32'($signed(y) >>> sh);
            6'h08: return y >> sh;
            6'h09: return (ix < iy) ? 32'd1 : 32'd0;
            6'h0A: return (x < y) ? 32'd1 : 32'd0;
            6'h0B: begin p = ux * uy; return p[31:0]; end
            6'h0C: begin p = sx * sy; return p[63:32]; end
            6'h0D: begin p = ux * uy; return p[63:32]; end
            6'h0E: begin p = sx * uy; return p[63:32]; end
            6'h0F: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return x;
                return 32'(ix / iy);
            end
            6'h10: begin
                if (y == 0) return 32'hFFFF_FFFF;
                return x / y;
            end
            6'h11: begin
                if (y == 0) return x;
                if (ovf) return 32'h0;
                return 32'(ix % iy);
            end
            6'h12: begin
                if (y == 0) return x;
                return x % y;
            end
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
            prev_ov   = 1'b0;
            prev_take = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    if (!prev_ov || prev_take)
                        chk($sformatf("latency op%02h", sb_q[0].op), 32'(cyc - sb_q[0].acc_cyc), 32'(sb_q[0].lat));
                    chk($sformatf("result op%02h", sb_q[0].op), result, sb_q[0].res);
                    if (out_ready) void'(sb_q.pop_front());
                end
            end
            prev_ov   = out_valid;
            prev_take = out_valid && out_ready;
            if (in_valid && in_ready) begin
                e.res     = model(op, a, b);
                e.acc_cyc = cyc;
                e.lat     = is_iter(op) ? ITER_LAT : 1;
                e.op      = op;
                sb_q.push_back(e);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [5:0] o, input logic [31:0] va, input logic [31:0] vb);
        bit done = 1'b0;
        in_valid = 1'b1;
        op = o;
        a  = va;
        b  = vb;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 32'(done), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        while (sb_q.size() != 0 && i < 400) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("drain_pending", 32'(sb_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        send(6'h01, 32'h7FFF_FFFF, 32'h0000_0001);
        send(6'h0A, 32'h0000_0001, 32'hFFFF_FFFF);
        send(6'h09, 32'h0000_0001, 32'hFFFF_FFFF);
        send(6'h07, 32'h0000_0004, 32'hF000_0000);
        send(6'h08, 32'h0000_0004, 32'hF000_0000);
        send(6'h06, 32'd36,        32'h0000_0001);
        send(6'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send(6'h0D, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send(6'h0E, 32'hFFFF_FFFF, 32'h0000_0002);
        send(6'h0F, 32'hFFFF_FFF9, 32'h0000_0002);
        send(6'h11, 32'hFFFF_FFF9, 32'h0000_0002);
        send(6'h10, 32'h0000_0007, 32'h0000_0000);
        send(6'h12, 32'h0000_0007, 32'h0000_0000);
        send(6'h0F, 32'h8000_0000, 32'hFFFF_FFFF);
        send(6'h11, 32'h8000_0000, 32'hFFFF_FFFF);
        send(6'h2A, 32'h0000_0005, 32'h0000_0006);
        drain();

        out_ready = 1'b0;
        send(6'h01, 32'd100, 32'd23);
        for (int i = 0; i < 10 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result", result, 32'd123);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(6'h05, 32'hA5A5_0000, 32'h0000_5A5A);
        drain();

        send(6'h10, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (9) @(posedge clk);
        #1;
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midrun_rst_busy", 32'(busy), 32'd0);
        chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(6'h01, 32'd2, 32'd3);
        drain();

        rand_bp = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int          r;
            logic [5:0]  o;
            r = $urandom_range(0, 19);
            o = (r == 19) ? 6'($urandom_range(19, 63)) : 6'(r);
            send(o, pick_operand(), pick_operand());
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();
        rand_bp = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
